lcd_hex_line_composer: RTL

LCD_HEX_LINE_COMPOSER -- requirements
Module: lcd_hex_line_composer

---
 rtl/lcd_text_functions_pkg.sv | 24 ++
 rtl/lcd_hex_line_composer.sv | 113 +++++++++++
 2 files changed

// File: rtl/lcd_text_functions_pkg.sv
// Shared text helpers for LCD line composition: hex-to-ASCII mapping, the
// composer state encoding and common character constants.
package lcd_text_functions_pkg;

    localparam int LINE_CHARS = 16;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CONVERT,
        ST_PRESENT
    } state_t;

    // Uppercase hex: 0-9 -> '0'-'9', A-F -> 'A'-'F'
    function automatic logic [7:0] hex_to_ascii(input logic [3:0] nibble);
        if (nibble < 4'd10) begin
            hex_to_ascii = 8'h30 + {4'd0, nibble};
        end else begin
            hex_to_ascii = 8'h37 + {4'd0, nibble};
        end
    endfunction

endpackage

// File: rtl/lcd_hex_line_composer.sv
// Composes a 16-char LCD line: ASCII label followed by a value in hex, one digit per cycle.
// Optional macro LCD_HEX_BLANK_LEADING_ZEROS_EN renders leading zero digits as spaces.
module lcd_hex_line_composer
    import lcd_text_functions_pkg::*;
#(
    parameter int PARM_DIGITS      = 8,
    parameter int PARM_LABEL_CHARS = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_start,
    input  logic [8*PARM_LABEL_CHARS-1:0] i_label,
    input  logic [4*PARM_DIGITS-1:0]      i_value,
    output logic                          o_idle,
    output logic [127:0]                  o_line,
    output logic                          o_line_valid,
    input  logic                          i_line_ready
);

    localparam int CNT_W   = $clog2(PARM_DIGITS + 1);
    localparam int VALUE_W = 4 * PARM_DIGITS;

    state_t                          state;
    logic [CNT_W-1:0]                cnt;
    logic [8*PARM_LABEL_CHARS-1:0]   label_q;
    logic [VALUE_W-1:0]              value_q;
    logic [127:0]                    line_q;
    logic                            valid_q;
    logic                            idle_q;
    logic [3:0]                      nibble;
    logic                            last_digit;
    logic [7:0]                      digit_char;

    // value_q shifts left each CONVERT cycle, so the current digit is always the top nibble
    assign nibble     = value_q[VALUE_W-1 -: 4];
    assign last_digit = (cnt == CNT_W'(PARM_DIGITS - 1));

`ifdef LCD_HEX_BLANK_LEADING_ZEROS_EN
    logic seen_nonzero;

    always_comb begin
        digit_char = hex_to_ascii(nibble);
        if ((nibble == 4'd0) && !seen_nonzero && !last_digit) begin
            digit_char = ASCII_SPACE;
        end
    end
`else
    always_comb begin
        digit_char = hex_to_ascii(nibble);
    end
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            line_q  <= {LINE_CHARS{ASCII_SPACE}};
            valid_q <= 1'b0;
            idle_q  <= 1'b1;
`ifdef LCD_HEX_BLANK_LEADING_ZEROS_EN
            seen_nonzero <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        label_q <= i_label;
                        value_q <= i_value;
                        idle_q  <= 1'b0;
                        state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    line_q <= {label_q, {PARM_DIGITS{ASCII_SPACE}}};
                    cnt    <= '0;
`ifdef LCD_HEX_BLANK_LEADING_ZEROS_EN
                    seen_nonzero <= 1'b0;
`endif
                    state  <= ST_CONVERT;
                end
                ST_CONVERT: begin
                    line_q[8*(LINE_CHARS-1-PARM_LABEL_CHARS-int'(cnt)) +: 8] <= digit_char;
                    value_q <= value_q << 4;
                    cnt     <= cnt + CNT_W'(1);
`ifdef LCD_HEX_BLANK_LEADING_ZEROS_EN
                    seen_nonzero <= seen_nonzero | (nibble != 4'd0);
`endif
                    if (last_digit) begin
                        valid_q <= 1'b1;
                        state   <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (i_line_ready) begin
                        valid_q <= 1'b0;
                        idle_q  <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    idle_q  <= 1'b1;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_idle       = idle_q;
    assign o_line       = line_q;
    assign o_line_valid = valid_q;

endmodule
